// File: rtl/square_draw_sched_if.sv
// square_draw_sched_if: groups the requester, engine and VGA signals of the
// square-fill scheduler. The scheduler connects through the slave modport;
// the game-logic / engine / VGA side uses the master modport.
//
// Handshake: req[i] is a level request. Requester i holds req[i] and its
// req_x/req_y/req_colour slices until it sees ack[i] (a one-cycle pulse).
// It drops req[i] on that same edge. Slices are only sampled while the
// scheduler is idle, so they may change once the job has been granted.
interface square_draw_sched_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req;
  logic [9*NUM_REQ-1:0] req_x;
  logic [8*NUM_REQ-1:0] req_y;
  logic [3*NUM_REQ-1:0] req_colour;
  logic [NUM_REQ-1:0]   ack;
  logic                 busy;
  logic                 err;
  logic                 eng_rst_n;
  logic                 eng_start;
  logic [2:0]           eng_colour;
  logic                 eng_done;
  logic [8:0]           eng_x;
  logic [7:0]           eng_y;
  logic [2:0]           eng_vga_colour;
  logic                 eng_plot;
  logic [8:0]           vga_x;
  logic [7:0]           vga_y;
  logic [2:0]           vga_colour;
  logic                 vga_plot;

  modport slave (
    input  req, req_x, req_y, req_colour,
    input  eng_done, eng_x, eng_y, eng_vga_colour, eng_plot,
    output ack, busy, err, eng_rst_n, eng_start, eng_colour,
    output vga_x, vga_y, vga_colour, vga_plot
  );

  modport master (
    output req, req_x, req_y, req_colour,
    output eng_done, eng_x, eng_y, eng_vga_colour, eng_plot,
    input  ack, busy, err, eng_rst_n, eng_start, eng_colour,
    input  vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/square_draw_sched.sv
// square_draw_sched: round-robin scheduler sharing one square-fill engine
// among NUM_REQ requesters. Each job latches the winner's origin and colour,
// pulses the engine reset, starts it, offsets its relative pixels by the
// origin, clips off-screen plots and acks the requester when done.
// Optional macro SQ_WATCHDOG_EN: aborts a job after TIMEOUT_CYC RUN cycles
// without eng_done and flags it on err.
module square_draw_sched #(
  parameter int NUM_REQ     = 4,
  parameter int SCR_W       = 160,
  parameter int SCR_H       = 120,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                clk,
  input  logic                rst,
  square_draw_sched_if.slave  bus,
  output logic [2:0]          dbg_state_o
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 2) begin : g_param_check
    $error("square_draw_sched: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_LAUNCH = 3'd2,
    S_RUN    = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, owner_q;
  logic [8:0]      org_x_q;
  logic [7:0]      org_y_q;
  logic [2:0]      colour_q;

  logic            grant_found;
  logic [PW-1:0]   grant_idx;
  int              cand;
  logic            run_done;
  logic [9:0]      sum_x;
  logic [8:0]      sum_y;

`ifdef SQ_WATCHDOG_EN
  localparam int CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0]   wd_cnt_q;
  logic            to_q;
  logic            wd_hit;
  assign wd_hit   = (wd_cnt_q == CW'(TIMEOUT_CYC - 1)) && !bus.eng_done;
  assign run_done = bus.eng_done || wd_hit;
`else
  assign run_done = bus.eng_done;
`endif

  // Round-robin search: first asserted req starting at rr_ptr, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!grant_found && bus.req[cand]) begin
        grant_found = 1'b1;
        grant_idx   = PW'(cand);
      end
    end
  end

  // Next-state logic for the job sequencer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (grant_found) state_d = S_CLEAR;
      S_CLEAR:  state_d = S_LAUNCH;
      S_LAUNCH: state_d = S_RUN;
      S_RUN:    if (run_done) state_d = S_FINISH;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, arbitration pointer and per-job latches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      org_x_q  <= '0;
      org_y_q  <= '0;
      colour_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && grant_found) begin
        owner_q  <= grant_idx;
        org_x_q  <= bus.req_x[9*grant_idx +: 9];
        org_y_q  <= bus.req_y[8*grant_idx +: 8];
        colour_q <= bus.req_colour[3*grant_idx +: 3];
      end
      if (state_q == S_FINISH) begin
        rr_ptr_q <= (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
      end
    end
  end

`ifdef SQ_WATCHDOG_EN
  // Watchdog: counts RUN cycles from zero; to_q marks an aborted job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt_q <= '0;
      to_q     <= 1'b0;
    end else begin
      wd_cnt_q <= (state_q == S_RUN) ? wd_cnt_q + 1'b1 : '0;
      to_q     <= (state_q == S_RUN) && wd_hit;
    end
  end
`endif

  // Control outputs decoded from state; engine held in reset while rst is high.
  always_comb begin
    bus.ack = '0;
    if (state_q == S_FINISH) bus.ack[owner_q] = 1'b1;
    bus.busy       = (state_q != S_IDLE);
    bus.eng_rst_n  = !rst && (state_q != S_CLEAR);
    bus.eng_start  = (state_q == S_LAUNCH);
    bus.eng_colour = (state_q == S_IDLE) ? 3'd0 : colour_q;
`ifdef SQ_WATCHDOG_EN
    bus.err = (state_q == S_FINISH) && to_q;
`else
    bus.err = 1'b0;
`endif
  end

  // Pixel path: zero-latency origin offset with carry-aware clipping.
  always_comb begin
    sum_x          = {1'b0, org_x_q} + {1'b0, bus.eng_x};
    sum_y          = {1'b0, org_y_q} + {1'b0, bus.eng_y};
    bus.vga_x      = sum_x[8:0];
    bus.vga_y      = sum_y[7:0];
    bus.vga_colour = bus.eng_vga_colour;
    bus.vga_plot   = bus.eng_plot && (state_q == S_RUN) &&
                     (sum_x < 10'(SCR_W)) && (sum_y < 9'(SCR_H));
  end

  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_square_draw_sched.sv
// tb_square_draw_sched: directed bench for square_draw_sched with a simple
// square-fill engine model, a pixel scoreboard and an ack log.
module tb_square_draw_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] dbg_state;

  square_draw_sched_if #(.NUM_REQ(4)) bus ();

  square_draw_sched #(
    .NUM_REQ(4), .SCR_W(160), .SCR_H(120), .TIMEOUT_CYC(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state_o(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [19:0] exp_q[$];
  logic [4:0]  ack_log[$];
  int plot_cnt = 0;
  int drop_cnt = 0;
  int eng_w = 7;
  int eng_h = 8;
  logic eng_hang = 1'b0;
  logic e_run;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Engine model: sweeps eng_w x eng_h relative pixels, then raises done
  always @(posedge clk) begin
    if (!bus.eng_rst_n) begin
      e_run <= 1'b0;
      bus.eng_plot <= 1'b0;
      bus.eng_done <= 1'b0;
      bus.eng_x <= '0;
      bus.eng_y <= '0;
      bus.eng_vga_colour <= '0;
    end else if (bus.eng_start && !e_run && !bus.eng_done) begin
      e_run <= 1'b1;
      bus.eng_plot <= 1'b1;
      bus.eng_x <= '0;
      bus.eng_y <= '0;
      bus.eng_vga_colour <= bus.eng_colour;
    end else if (e_run) begin
      if (bus.eng_x == 9'(eng_w - 1)) begin
        bus.eng_x <= '0;
        if (bus.eng_y == 8'(eng_h - 1)) begin
          e_run <= 1'b0;
          bus.eng_plot <= 1'b0;
          bus.eng_done <= !eng_hang;
        end else begin
          bus.eng_y <= bus.eng_y + 8'd1;
        end
      end else begin
        bus.eng_x <= bus.eng_x + 9'd1;
      end
    end
  end

  // Scoreboard / monitor on the falling edge
  always @(negedge clk) begin
    if (bus.vga_plot) begin
      plot_cnt++;
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_plot", {bus.vga_x, bus.vga_y, bus.vga_colour}, 32'hFFFFFFFF);
      end else begin
        chk("sb_pixel", {bus.vga_x, bus.vga_y, bus.vga_colour}, exp_q.pop_front());
      end
    end
    if (bus.eng_plot && bus.busy && !bus.vga_plot) drop_cnt++;
    if (bus.ack != '0) ack_log.push_back({bus.err, bus.ack});
  end

  // Driver tasks
  task automatic tick();
    @(negedge clk);
    if (bus.ack != '0) bus.req = bus.req & ~bus.ack;
  endtask

  task automatic set_slot(input int i, input logic [8:0] x, input logic [7:0] y, input logic [2:0] c);
    bus.req_x[9*i +: 9]      = x;
    bus.req_y[8*i +: 8]      = y;
    bus.req_colour[3*i +: 3] = c;
  endtask

  task automatic push_square(input int ox, input int oy, input int col, input int w, input int h);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (ox + x < 160 && oy + y < 120)
          exp_q.push_back({9'(ox + x), 8'(oy + y), 3'(col)});
      end
    end
  endtask

  task automatic wait_acks(input int n, input int budget, input string tag);
    int c = 0;
    while (ack_log.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk(tag, ack_log.size(), n);
  endtask

  int pb, db, ab, n;

  initial begin
    bus.req = '0; bus.req_x = '0; bus.req_y = '0; bus.req_colour = '0;
    repeat (3) @(negedge clk);
    // Reset values
    chk("rst_busy", bus.busy, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_eng_start", bus.eng_start, 0);
    chk("rst_eng_rst_n", bus.eng_rst_n, 0);
    chk("rst_vga_plot", bus.vga_plot, 0);
    chk("rst_vga_xyc", {bus.vga_x, bus.vga_y, bus.vga_colour}, 0);
    chk("rst_state", dbg_state, 0);
    @(posedge clk); #1 rst = 1'b0;
    tick();
    chk("idle_eng_rst_n", bus.eng_rst_n, 1);
    chk("idle_busy", bus.busy, 0);

    // Single request: requester 1, origin (20,30), colour 5, 7x8
    set_slot(1, 9'd20, 8'd30, 3'd5);
    push_square(20, 30, 5, 7, 8);
    pb = plot_cnt; ab = ack_log.size();
    @(posedge clk); #1 bus.req = 4'b0010;
    tick();
    chk("single_idle_colour", bus.eng_colour, 0);
    chk("single_idle_busy", bus.busy, 0);
    tick();
    chk("single_clear_rst_n", bus.eng_rst_n, 0);
    chk("single_clear_busy", bus.busy, 1);
    chk("single_clear_colour", bus.eng_colour, 5);
    chk("single_clear_start", bus.eng_start, 0);
    tick();
    chk("single_launch_start", bus.eng_start, 1);
    chk("single_launch_rst_n", bus.eng_rst_n, 1);
    tick();
    chk("single_run_start", bus.eng_start, 0);
    chk("single_run_first_px", {bus.vga_plot, bus.vga_x, bus.vga_y}, {1'b1, 9'd20, 8'd30});
    wait_acks(ab + 1, 200, "single_ack_seen");
    chk("single_ack", ack_log[ab], {1'b0, 4'b0010});
    chk("single_plots", plot_cnt - pb, 56);
    chk("single_sb_empty", exp_q.size(), 0);
    tick(); tick();
    chk("single_ack_once", ack_log.size(), ab + 1);
    chk("single_busy_after", bus.busy, 0);

    // Reset in the middle of a job for requester 2
    set_slot(2, 9'd0, 9'd0, 3'd1);
    push_square(0, 0, 1, 7, 8);
    @(posedge clk); #1 bus.req = 4'b0100;
    n = 0;
    while (!bus.vga_plot && n < 50) begin tick(); n++; end
    chk("rstmid_plotting", bus.vga_plot, 1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_vga_plot", bus.vga_plot, 0);
    chk("rstmid_busy", bus.busy, 0);
    chk("rstmid_eng_rst_n", bus.eng_rst_n, 0);
    exp_q.delete();
    bus.req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    ab = ack_log.size();
    repeat (20) tick();
    chk("rstmid_no_ack", ack_log.size(), ab);
    // Pointer must restart at 0
    set_slot(0, 9'd50, 8'd50, 3'd2);
    set_slot(2, 9'd60, 8'd60, 3'd3);
    eng_w = 2; eng_h = 2;
    push_square(50, 50, 2, 2, 2);
    push_square(60, 60, 3, 2, 2);
    @(posedge clk); #1 bus.req = 4'b0101;
    wait_acks(ab + 2, 100, "rstmid_acks_seen");
    chk("rstmid_first_grant", ack_log[ab], {1'b0, 4'b0001});
    chk("rstmid_second_grant", ack_log[ab + 1], {1'b0, 4'b0100});

    // Clipping at origin (155,115) with requester 3, 7x8 square
    eng_w = 7; eng_h = 8;
    set_slot(3, 9'd155, 8'd115, 3'd6);
    push_square(155, 115, 6, 7, 8);
    pb = plot_cnt; db = drop_cnt; ab = ack_log.size();
    @(posedge clk); #1 bus.req = 4'b1000;
    wait_acks(ab + 1, 200, "clip_ack_seen");
    chk("clip_ack", ack_log[ab], {1'b0, 4'b1000});
    chk("clip_plots", plot_cnt - pb, 25);
    chk("clip_drops", drop_cnt - db, 31);
    chk("clip_sb_empty", exp_q.size(), 0);

    // Round robin with all four requesting
    eng_w = 2; eng_h = 2;
    for (int i = 0; i < 4; i++) begin
      set_slot(i, 9'(10 * i), 8'd0, 3'(i + 1));
      push_square(10 * i, 0, i + 1, 2, 2);
    end
    ab = ack_log.size();
    @(posedge clk); #1 bus.req = 4'b1111;
    wait_acks(ab + 4, 200, "rr_acks_seen");
    chk("rr_grant0", ack_log[ab],     {1'b0, 4'b0001});
    chk("rr_grant1", ack_log[ab + 1], {1'b0, 4'b0010});
    chk("rr_grant2", ack_log[ab + 2], {1'b0, 4'b0100});
    chk("rr_grant3", ack_log[ab + 3], {1'b0, 4'b1000});
    push_square(0, 0, 1, 2, 2);
    push_square(20, 0, 3, 2, 2);
    bus.req = 4'b0101;
    wait_acks(ab + 6, 100, "rr_reraise_seen");
    chk("rr_reraise0", ack_log[ab + 4], {1'b0, 4'b0001});
    chk("rr_reraise2", ack_log[ab + 5], {1'b0, 4'b0100});
    chk("rr_sb_empty", exp_q.size(), 0);

    // Carry overflow origin (510,250): nothing plotted, ack still pulses
    eng_w = 7; eng_h = 8;
    set_slot(3, 9'd510, 8'd250, 3'd7);
    pb = plot_cnt; db = drop_cnt; ab = ack_log.size();
    @(posedge clk); #1 bus.req = 4'b1000;
    wait_acks(ab + 1, 200, "ovf_ack_seen");
    chk("ovf_ack", ack_log[ab], {1'b0, 4'b1000});
    chk("ovf_plots", plot_cnt - pb, 0);
    chk("ovf_drops", drop_cnt - db, 56);

    // Data latching: x origin changes from 10 to 90 after grant
    eng_w = 2; eng_h = 2;
    set_slot(0, 9'd10, 8'd5, 3'd2);
    push_square(10, 5, 2, 2, 2);
    pb = plot_cnt; ab = ack_log.size();
    @(posedge clk); #1 bus.req = 4'b0001;
    tick();
    tick();
    chk("latch_in_clear", bus.eng_rst_n, 0);
    set_slot(0, 9'd90, 8'd5, 3'd2);
    wait_acks(ab + 1, 100, "latch_ack_seen");
    chk("latch_plots", plot_cnt - pb, 4);
    chk("latch_sb_empty", exp_q.size(), 0);

    // Engine that never reports done
    eng_hang = 1'b1;
    set_slot(1, 9'd40, 8'd40, 3'd4);
    push_square(40, 40, 4, 2, 2);
    ab = ack_log.size();
    @(posedge clk); #1 bus.req = 4'b0010;
    n = 0;
    while (!bus.eng_start && n < 20) begin tick(); n++; end
    chk("hang_launch", bus.eng_start, 1);
`ifdef SQ_WATCHDOG_EN
    n = 0;
    while (bus.ack == '0 && n < 40) begin tick(); n++; end
    chk("wd_latency", n, 17);
    chk("wd_ack", bus.ack, 4'b0010);
    chk("wd_err", bus.err, 1);
    tick();
    chk("wd_err_pulse", bus.err, 0);
    chk("wd_busy_after", bus.busy, 0);
`else
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (!bus.busy) n++;
    end
    chk("hang_busy_low_cycles", n, 0);
    chk("hang_no_ack", ack_log.size(), ab);
    chk("hang_err", bus.err, 0);
`endif
    chk("hang_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/square_draw_sched.md
Name: square_draw_sched

Overview:
- Round-robin scheduler that shares one square-fill drawing engine among NUM_REQ game-object requesters.
- Sits between the game logic and the VGA adapter.
- Latches a requester's origin and colour, resets then starts the engine, and offsets the engine's relative pixel coordinates by the origin.
- Clips off-screen pixels, forwards plots to the VGA port and acknowledges the requester on completion.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- SCR_W, 160, screen width in pixels; plots with x >= SCR_W are suppressed
- SCR_H, 120, screen height in pixels; plots with y >= SCR_H are suppressed
- TIMEOUT_CYC, 1024, watchdog limit in cycles (used only with SQ_WATCHDOG_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- req  in  NUM_REQ  level request per requester; held until ack
- req_x  in  9*NUM_REQ  packed origin x; slice i = [9i+8:9i]
- req_y  in  8*NUM_REQ  packed origin y
- req_colour  in  3*NUM_REQ  packed colour
- ack  out  NUM_REQ  one-hot, one-cycle pulse when requester's square completes
- busy  out  1  high in any state except IDLE
- err  out  1  one-cycle pulse on watchdog abort (tied 0 without macro)
- eng_rst_n  out  1  active-low reset to engine
- eng_start  out  1  engine start
- eng_colour  out  3  colour driven to engine
- eng_done  in  1  engine done
- eng_x  in  9  engine relative x
- eng_y  in  8  engine relative y
- eng_vga_colour  in  3  engine colour output
- eng_plot  in  1  engine plot strobe
- vga_x  out  9  absolute x to VGA adapter
- vga_y  out  8  absolute y
- vga_colour  out  3  colour to VGA
- vga_plot  out  1  plot strobe to VGA

Behaviour:
- Clocking/reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, rr_ptr=0, latched origin/colour/owner=0, watchdog count=0.
  - ack=0, busy=0, err=0, eng_start=0, eng_rst_n=0.
  - vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
- Reset mid-job: aborts with no ack; engine held in reset (eng_rst_n=0) for the whole time rst is high.
- FSM states:
  - IDLE: eng_rst_n=1, eng_start=0.
    - If any req is high, pick the first set bit searching from rr_ptr upward (wrapping).
    - Latch owner index, origin x/y and colour for that requester; go to CLEAR. Otherwise stay.
  - CLEAR: eng_rst_n=0 for exactly one cycle, which returns the engine to its wait state; -> LAUNCH.
  - LAUNCH: eng_rst_n=1, eng_start=1 for one cycle; -> RUN.
  - RUN: eng_start=0; forward pixels.
    - eng_done=1 -> FINISH.
  - FINISH: ack[owner]=1 for one cycle; rr_ptr <= (owner+1) mod NUM_REQ; -> IDLE.
- Request rules:
  - req and its data slices are sampled only in IDLE.
  - Changes to req_x/req_y/req_colour after the grant have no effect on the current job.
  - The requester drops req on the edge where it sees ack. Back-to-back service of the same requester therefore needs it to re-raise req.
- eng_colour = latched colour in all non-IDLE states, 0 in IDLE.
- Pixel path (combinational from engine outputs and latched origin, zero latency):
  - sum_x = {1'b0, org_x} + {1'b0, eng_x} (10 bits); sum_y = {1'b0, org_y} + {1'b0, eng_y} (9 bits).
  - vga_x = sum_x[8:0]; vga_y = sum_y[7:0]; vga_colour = eng_vga_colour.
  - vga_plot = eng_plot AND state==RUN AND sum_x < SCR_W AND sum_y < SCR_H. Out-of-range pixels are silently dropped and carry overflow counts as out of range.
  - Outside RUN, vga_plot=0.
- Arbitration fairness: with all requesters asserting continuously, grants rotate 0,1,2,3,0,...
- Overhead: 3 cycles per job (CLEAR, LAUNCH, FINISH) plus one IDLE cycle between jobs.

Optional Feature:
- Macro: SQ_WATCHDOG_EN.
- Defined:
  - A cycle counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches TIMEOUT_CYC-1 without eng_done, go to FINISH, pulse err=1 together with ack[owner], and treat the job as complete.
  - If eng_done and timeout coincide, eng_done wins and err stays 0.
- Not defined: no counter; err tied 0; RUN waits indefinitely for eng_done.

Test Plan:
- Reset mid-RUN: assert rst while the engine is plotting -> same cycle vga_plot=0, busy=0, eng_rst_n=0; no ack after release; next grant starts from requester 0.
- Single request: req=4'b0010, origin (20,30), colour 3'd5; engine model emits eng_x 0..6, eng_y 0..7 -> 56 plots at x 20..26, y 30..37, colour 5; ack=4'b0010 for exactly one cycle; busy=0 afterwards.
- Round robin: req=4'b1111 held, each requester dropping on its ack -> ack order 0,1,2,3.
  - Re-raise req0 and req2 immediately -> order continues 0 then 2.
- Clipping: origin (155,115) -> only the 5x5 pixels with x 155..159, y 115..119 plotted; the remaining 31 pixels have vga_plot=0.
  - Origin (510,250) -> carry overflow, zero plots; ack still pulses.
- Data latching: change req_x from 10 to 90 one cycle after grant -> all plots use x origin 10.
- Watchdog (SQ_WATCHDOG_EN, TIMEOUT_CYC=16): engine never asserts eng_done -> ack and err pulse together 16 cycles after RUN entry.
  - Without the macro: busy stays 1 for 1000 cycles.
